// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and width constants for the multiply/divide path
//
// Purpose:
//   Holds the operation and FSM state enumerations used by mul_div_unit and
//   md_step, the default datapath/register-address widths, and small decode
//   helpers for the operation code.
// Ports: none (package).

package riscv_pkg;

    localparam int XLEN       = 8;
    localparam int REG_ADDR_W = 4;

    typedef enum logic [1:0] {
        MD_MUL  = 2'b00,
        MD_MULH = 2'b01,
        MD_DIV  = 2'b10,
        MD_REM  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } md_state_e;

    // op[1] separates the divide family from the multiply family.
    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    // op[0] selects the upper half of the working register: MULH takes the
    // product high half and REM takes the partial remainder, both of which
    // live in the upper half after the last iteration.
    function automatic logic md_takes_high(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/md_step.sv
// rtl/md_step.sv - one combinational shift-add / restoring-divide iteration
//
// Purpose:
//   Computes a single iteration of either the shift-add multiplier or the
//   restoring divider on the shared 2*WIDTH working register.
//
//   Multiply layout : i_acc = {partial product high (WIDTH), multiplier/low product (WIDTH)}
//   Divide layout   : i_acc = {partial remainder (WIDTH), dividend/quotient (WIDTH)}
//
// Ports:
//   i_is_div   in   1        1 = divide iteration, 0 = multiply iteration
//   i_acc      in   2*WIDTH  current working register
//   i_operand  in   WIDTH    multiplicand (multiply) or divisor (divide)
//   o_acc      out  2*WIDTH  next working register (quotient bit slot left 0)
//   o_q_bit    out  1        quotient bit produced by a divide iteration

import riscv_pkg::*;

module md_step #(
    parameter int WIDTH = XLEN
) (
    input  logic               i_is_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_q_bit
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted_rem;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_rem_next;

    always_comb begin
        // Multiply: conditionally add the multiplicand into the high half;
        // the carry becomes the new top bit after the right shift.
        w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
              + {1'b0, (i_acc[0] ? i_operand : {WIDTH{1'b0}})};

        // Divide: the partial remainder is WIDTH+1 bits wide only for the
        // duration of the trial subtraction. A restored remainder is always
        // below the divisor, so it fits back into WIDTH bits, and when the
        // subtraction succeeds the true difference also fits in WIDTH bits,
        // which lets the difference be taken modulo 2^WIDTH.
        w_shifted_rem = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_fits        = (w_shifted_rem >= {1'b0, i_operand});
        w_diff        = w_shifted_rem[WIDTH-1:0] - i_operand;
        w_rem_next    = w_fits ? w_diff : w_shifted_rem[WIDTH-1:0];

        o_acc   = '0;
        o_q_bit = 1'b0;
        if (i_is_div) begin
            o_q_bit = w_fits;
            o_acc   = {w_rem_next, i_acc[WIDTH-2:0], 1'b0};
        end else begin
            o_acc   = {w_sum, i_acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative unsigned multiply/divide unit with register write-back
//
// Purpose:
//   Multi-cycle M-extension path between the register file read ports and its
//   write port. One operation runs WIDTH iterations of md_step, then presents
//   the result on the write-back port for exactly one cycle.
//
// Ports:
//   clk      in   1       rising-edge clock
//   reset    in   1       synchronous active-high reset
//   start    in   1       begin an operation (sampled only in IDLE)
//   op       in   2       00 MUL, 01 MULH, 10 DIV, 11 REM
//   src_a    in   WIDTH   multiplicand / dividend
//   src_b    in   WIDTH   multiplier / divisor
//   rd       in   ADDR_W  destination register
//   busy     out  1       high in CALC and DONE
//   done     out  1       one-cycle pulse in DONE
//   wb_en    out  1       register write enable (DONE and rd != 0)
//   wb_addr  out  ADDR_W  register write address (registered)
//   wb_data  out  WIDTH   register write data (registered)

import riscv_pkg::*;

module mul_div_unit #(
    parameter int WIDTH  = XLEN,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [ADDR_W-1:0] rd,
    output logic              busy,
    output logic              done,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [WIDTH-1:0]  wb_data
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e          r_state;
    md_state_e          w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    md_op_e             r_op;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [ADDR_W-1:0]  r_rd;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [WIDTH-1:0]   r_wb_data;

    logic [2*WIDTH-1:0] w_step_acc;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_result;
    logic               w_start_div;

    md_step #(.WIDTH(WIDTH)) u_md_step (
        .i_is_div  (md_is_div(r_op)),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_step_acc),
        .o_q_bit   (w_q_bit)
    );

    // The quotient bit shifts into the LSB of the dividend half; md_step
    // leaves that slot at 0 for divides and the multiply path never sets
    // w_q_bit, so an OR merges both cases.
    assign w_acc_next  = {w_step_acc[2*WIDTH-1:1], w_step_acc[0] | w_q_bit};
    assign w_result    = md_takes_high(r_op) ? w_acc_next[2*WIDTH-1:WIDTH]
                                             : w_acc_next[WIDTH-1:0];
    assign w_start_div = op[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_op      <= MD_MUL;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_rd      <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op  <= md_op_e'(op);
                        r_rd  <= rd;
                        r_cnt <= '0;
                        // Multiply keeps the multiplicand as the step operand
                        // and shifts the multiplier through the low half;
                        // divide keeps the divisor and shifts the dividend.
                        if (w_start_div) begin
                            r_opnd <= src_b;
                            r_acc  <= {{WIDTH{1'b0}}, src_a};
                        end else begin
                            r_opnd <= src_a;
                            r_acc  <= {{WIDTH{1'b0}}, src_b};
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_wb_data <= w_result;
                        r_wb_addr <= r_rd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        wb_en        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == LAST_ITER) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                wb_en        = (r_rd != '0);
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard testbench for mul_div_unit

module tb_mul_div_unit;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          start  = 1'b0;
    logic [1:0]    op     = 2'b00;
    logic [W-1:0]  src_a  = '0;
    logic [W-1:0]  src_b  = '0;
    logic [AW-1:0] rd     = '0;
    logic          busy;
    logic          done;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        logic          en;
        int            done_cyc;
    } exp_t;

    exp_t sb[$];

    mul_div_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .rd      (rd),
        .busy    (busy),
        .done    (done),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic with RISC-V divide-by-zero rules.
    function automatic logic [W-1:0] ref_result(input logic [1:0] o,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned prod;
        ua   = a;
        ub   = b;
        prod = ua * ub;
        case (o)
            2'b00:   return W'(prod % (1 << W));
            2'b01:   return W'(prod / (1 << W));
            2'b10:   return (ub == 0) ? {W{1'b1}} : W'(ua / ub);
            default: return (ub == 0) ? a : W'(ua % ub);
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_en && !done) chk("wb_en_without_done", {31'b0, done}, 32'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", sb.size(), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_data", {24'b0, wb_data}, {24'b0, e.data});
                    chk("wb_addr", {28'b0, wb_addr}, {28'b0, e.addr});
                    chk("wb_en",   {31'b0, wb_en},   {31'b0, e.en});
                    chk("done_latency", cyc, e.done_cyc);
                end
            end
        end
    end

    // Start sampled at the next edge k; done is visible at the negedge
    // following edge k+8, where cyc == k+8.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] r, input bit push, input logic [W-1:0] expd);
        @(negedge clk);
        op    = o;
        src_a = a;
        src_b = b;
        rd    = r;
        start = 1'b1;
        if (push) sb.push_back('{r, expd, (r != 0), cyc + 9});
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30 && busy; i++) @(negedge clk);
        chk("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]    o;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] r;
        logic [W-1:0]  expd;
    } vec_t;

    vec_t dir[$] = '{
        '{2'b00, 8'd13,  8'd7, 4'd1, 8'h5B},
        '{2'b01, 8'd13,  8'd7, 4'd1, 8'h00},
        '{2'b00, 8'd200, 8'd3, 4'd5, 8'h58},
        '{2'b01, 8'd200, 8'd3, 4'd5, 8'h02},
        '{2'b10, 8'd100, 8'd7, 4'd2, 8'h0E},
        '{2'b11, 8'd100, 8'd7, 4'd2, 8'h02},
        '{2'b10, 8'd45,  8'd0, 4'd3, 8'hFF},
        '{2'b11, 8'd45,  8'd0, 4'd3, 8'h2D}
    };

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy",    {31'b0, busy},    32'd0);
        chk("reset_done",    {31'b0, done},    32'd0);
        chk("reset_wb_en",   {31'b0, wb_en},   32'd0);
        chk("reset_wb_addr", {28'b0, wb_addr}, 32'd0);
        chk("reset_wb_data", {24'b0, wb_data}, 32'd0);

        foreach (dir[i]) begin
            issue(dir[i].o, dir[i].a, dir[i].b, dir[i].r, 1'b1, dir[i].expd);
            wait_idle();
        end

        // Second start three edges into a DIV must be ignored.
        issue(2'b10, 8'd100, 8'd7, 4'd4, 1'b1, 8'h0E);
        @(negedge clk);
        @(negedge clk);
        op    = 2'b00;
        src_a = 8'd9;
        src_b = 8'd9;
        rd    = 4'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset four cycles into a DIV discards it: no done, no write.
        issue(2'b10, 8'd200, 8'd9, 4'd6, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midop_reset_busy",  {31'b0, busy},  32'd0);
        chk("midop_reset_done",  {31'b0, done},  32'd0);
        chk("midop_reset_wb_en", {31'b0, wb_en}, 32'd0);
        repeat (15) @(negedge clk);

        // rd = 0: done pulses, wb_en stays low.
        issue(2'b00, 8'd13, 8'd7, 4'd0, 1'b1, 8'h5B);
        wait_idle();

        for (int n = 0; n < 40; n++) begin
            logic [1:0]    o;
            logic [W-1:0]  a;
            logic [W-1:0]  b;
            logic [AW-1:0] r;
            o = 2'($urandom_range(0, 3));
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            r = AW'($urandom);
            issue(o, a, b, r, 1'b1, ref_result(o, a, b));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative unsigned multiply/divide unit. It sits directly downstream of the register file read ports and upstream of its write port.
- Operands come from the two register read outputs. The result goes back through the register file write port (write address, write data, write enable).
- Gives the single-cycle core a multi-cycle M-extension path. The main ALU stays purely combinational.

Parameters:
- WIDTH, 8, data width; must match the register file data width.
- ADDR_W, 4, register address width; must match the register file address width.

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request to begin an operation; sampled only in IDLE
- op  input  2  00 MUL (low half), 01 MULH (high half), 10 DIV (quotient), 11 REM (remainder)
- src_a  input  WIDTH  operand A (multiplicand / dividend), from register read port 1
- src_b  input  WIDTH  operand B (multiplier / divisor), from register read port 2
- rd  input  ADDR_W  destination register address
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse in DONE
- wb_en  output  1  drives register file write enable; high in DONE when rd != 0
- wb_addr  output  ADDR_W  drives register file write address
- wb_data  output  WIDTH  drives register file write data

Behaviour:
- Reset: state=IDLE, counter=0, all internal registers=0. Outputs busy=0, done=0, wb_en=0, wb_addr=0, wb_data=0.
- FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on an edge with start=1. On that edge latch op, src_a, src_b and rd, and clear counter to 0. With start=0, stay in IDLE.
- CALC: one iteration per edge, WIDTH iterations total. Counter increments each edge. On the edge where counter==WIDTH-1, go to DONE.
- DONE -> IDLE unconditionally after one cycle.
- Latency: start sampled at edge k gives DONE during the cycle after edge k+WIDTH. The register file write commits at edge k+WIDTH+1. The next start is accepted at edge k+WIDTH+1 at the earliest.
- start in CALC or DONE: ignored; latched operands and rd are unchanged.
- Multiply: shift-add on a 2*WIDTH accumulator. MUL returns bits [WIDTH-1:0]; MULH returns bits [2*WIDTH-1:WIDTH].
- Divide: restoring algorithm with a WIDTH+1-bit partial remainder. DIV returns the quotient; REM returns the remainder.
- Divide by zero: latency unchanged. DIV returns all ones; REM returns the dividend (RISC-V semantics).
- wb_data and wb_addr are registered and valid throughout DONE. Outside DONE they hold their last value; the bench checks them only when done=1.
- rd==0: done still pulses, wb_en stays 0 (x0 is never written).
- Reset asserted mid-operation: on that edge go to IDLE with busy=0, done=0, wb_en=0. The in-flight operation is discarded and no write-back occurs.
- No combinational path from any input to any output.

Decomposition:
- Shared package riscv_pkg holds:
  - md_op_e enum (MD_MUL, MD_MULH, MD_DIV, MD_REM)
  - md_state_e enum (IDLE, CALC, DONE)
  - XLEN=8 and REG_ADDR_W=4 constants, used as the parameter defaults.
- One sub-module, md_step: combinational single-iteration datapath.
  - Inputs: op class, accumulator/remainder, operand.
  - Outputs: next accumulator/remainder and quotient bit.
  - Instantiated once; the FSM, counter and registers stay in mul_div_unit.

Test Plan (WIDTH=8):
- Reset, then idle -> busy=0, done=0, wb_en=0, wb_addr=0, wb_data=0.
- MUL 13*7, rd=1, start at edge k -> done and wb_en high only in the cycle after edge k+8; wb_addr=1, wb_data=0x5B. Then MULH same operands -> 0x00.
- MUL 200*3 -> wb_data=0x58; MULH 200*3 -> wb_data=0x02; rd=5 -> wb_addr=5.
- DIV 100/7 -> 0x0E; REM 100/7 -> 0x02. DIV 45/0 -> 0xFF; REM 45/0 -> 0x2D, with the same 9-edge latency.
- Pulse start again (different operands) three edges into an operation -> ignored; result matches the first operands; exactly one done pulse.
- Reset asserted for one edge four cycles into a DIV -> busy=0 at the next edge and no done/wb_en pulse afterward. Then MUL 13*7 with rd=0 -> done pulses, wb_en stays 0.
